// File: rtl/ahblite_wait_state_slave_if.sv
// AHB-Lite slave-port bundle between a matrix slave stage and one responder.
// The master modport is the bus side; the slave modport is the responder side.
interface ahblite_wait_state_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA, HMASTLOCK, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA, HMASTLOCK, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahblite_wait_state_slave.sv
// AHB-Lite responder: word register array with byte-lane writes, a fixed number
// of OKAY wait states and the two-cycle ERROR response for illegal transfers.
module ahblite_wait_state_slave #(
    parameter int AW          = 6,
    parameter int WAIT_STATES = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESETN,
    ahblite_wait_state_slave_if.slave    bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [3:0] LP_WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t        r_state;
    logic [3:0]    r_wcnt;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic [2:0]    r_size;
    logic          r_write;
    logic          r_hreadyout;
    logic          r_hresp;
    logic [31:0]   r_hrdata;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_oow;
    logic          w_misalign;
    logic          w_err;
    logic [AW-1:0] w_addr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_commit;
    logic [3:0]    w_be;
    logic [31:0]   w_merged;
    logic [31:0]   w_rd_word;
    logic          w_unused;

    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2))
                        && bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign w_oow      = |(bus.HADDR[11:0] >> (AW + 2));
    assign w_misalign = ((bus.HSIZE == 3'b001) && bus.HADDR[0])
                      || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
    assign w_err      = w_oow || (bus.HSIZE > 3'b010) || w_misalign;
    assign w_addr_idx = bus.HADDR[AW+1:2];
    assign w_commit   = (r_state == S_DONE) && r_write;
    assign w_unused   = ^{bus.HBURST, bus.HMASTLOCK, bus.HADDR[31:12]};

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            3'b000:  w_be = 4'b0001 << r_lane;
            3'b001:  w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[8*gi +: 8] = w_be[gi] ? bus.HWDATA[8*gi +: 8] : r_mem[r_idx][8*gi +: 8];
        end
    endgenerate

    // A read entering DONE on the same edge a write commits must see the new data.
    assign w_rd_idx  = (r_state == S_WAIT) ? r_idx : w_addr_idx;
    assign w_rd_word = (w_commit && (w_rd_idx == r_idx)) ? w_merged : r_mem[w_rd_idx];

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_idx] <= w_merged;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_idx       <= '0;
            r_lane      <= '0;
            r_size      <= '0;
            r_write     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
        end else begin
            r_hrdata <= '0;
            case (r_state)
                S_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state     <= S_DONE;
                        r_hreadyout <= 1'b1;
                        r_hrdata    <= r_write ? 32'h0 : w_rd_word;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    // IDLE, DONE and ERR2 all branch identically on a new accept.
                    if (w_accept) begin
                        r_idx   <= w_addr_idx;
                        r_lane  <= bus.HADDR[1:0];
                        r_size  <= bus.HSIZE;
                        r_write <= bus.HWRITE;
                        if (w_err) begin
                            r_state     <= S_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state     <= S_DONE;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= 1'b0;
                            r_hrdata    <= bus.HWRITE ? 32'h0 : w_rd_word;
                        end else begin
                            r_state     <= S_WAIT;
                            r_wcnt      <= LP_WCNT_INIT;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b0;
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = r_hrdata;
endmodule
